// File: rtl/hazard_ctrl.sv
// Load-use stall, mispredict flush and memory-wait freeze sequencing for the 5-stage core.
// Control outputs are combinational (zero latency); memory waits are bounded by a watchdog.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_IF_ID,
  input  logic [4:0]       rs2_IF_ID,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic [4:0]       rd_ID_EX,
  input  logic             Mem_Read_ID_EX,
  input  logic             Miss_Prediction,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Clear,
  output logic             Pipe_Freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          freeze, timeout, load_use;
  logic          stall_inc, flush_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    timeout      = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WW'(1);
          freeze       = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
          // Watchdog expiry: let the pipeline go and flag the error.
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          timeout      = 1'b1;
        end else begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign load_use = Mem_Read_ID_EX && (rd_ID_EX != 5'd0) &&
                    ((uses_rs1 && (rs1_IF_ID == rd_ID_EX)) ||
                     (uses_rs2 && (rs2_IF_ID == rd_ID_EX)));

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Write = 1'b1;
    ID_EX_Clear = 1'b0;
    Pipe_Freeze = 1'b0;
    if (!rst_n) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Clear = 1'b1;
    end else if (freeze) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if (Miss_Prediction) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Clear = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Clear = 1'b1;
    end
  end

  // A mispredict subsumes a concurrent load-use bubble, so only one counter moves.
  assign stall_inc = freeze || (load_use && !Miss_Prediction);
  assign flush_inc = !freeze && Miss_Prediction;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (timeout)
        mem_err <= 1'b1;
      if (cnt_clr)
        stall_cnt <= '0;
      else if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (cnt_clr)
        flush_cnt <= '0;
      else if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_hazard_ctrl;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Clear, Pipe_Freeze}
  localparam logic [5:0] C_NORM = 6'b110100;
  localparam logic [5:0] C_FRZ  = 6'b000001;
  localparam logic [5:0] C_MISP = 6'b111110;
  localparam logic [5:0] C_LU   = 6'b000110;
  localparam logic [5:0] C_RST  = 6'b001010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_IF_ID, rs2_IF_ID, rd_ID_EX;
  logic       uses_rs1, uses_rs2, Mem_Read_ID_EX, Miss_Prediction;
  logic       mem_req, mem_ack, cnt_clr;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Clear, Pipe_Freeze;
  logic       mem_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [5:0] ctl;

  int tests = 0;
  int fails = 0;

  assign ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Clear, Pipe_Freeze};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rd_ID_EX(rd_ID_EX), .Mem_Read_ID_EX(Mem_Read_ID_EX),
    .Miss_Prediction(Miss_Prediction),
    .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Clear(ID_EX_Clear), .Pipe_Freeze(Pipe_Freeze),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_IF_ID = 5'd0; rs2_IF_ID = 5'd0; rd_ID_EX = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; Mem_Read_ID_EX = 1'b0;
    Miss_Prediction = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd);
    rs1_IF_ID = rs1; uses_rs1 = u1; rs2_IF_ID = rs2; uses_rs2 = u2;
    rd_ID_EX = rd; Mem_Read_ID_EX = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    tests++; if (ctl !== C_RST) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
    tests++; if (mem_err !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_state got err=%b stall=%0d flush=%0d want 0/0/0", mem_err, stall_cnt, flush_cnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_NORM); end
    tick();
  endtask

  task automatic test_load_use();
    clear_counters();
    set_hazard(5'd5, 1'b1, 5'd0, 1'b0, 5'd5);
    #1;
    tests++; if (ctl !== C_LU) begin fails++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
    tick();
    idle();
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL lu_release got %b want %b", ctl, C_NORM); end
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    set_hazard(5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL lu_rd0 got %b want %b", ctl, C_NORM); end
    tick();
    set_hazard(5'd5, 1'b0, 5'd0, 1'b0, 5'd5);
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL lu_unused got %b want %b", ctl, C_NORM); end
    tick();
    set_hazard(5'd1, 1'b1, 5'd9, 1'b1, 5'd9);
    #1;
    tests++; if (ctl !== C_LU) begin fails++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); end
    tick();
    idle();
    Mem_Read_ID_EX = 1'b0; rs1_IF_ID = 5'd7; uses_rs1 = 1'b1; rd_ID_EX = 5'd7;
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL lu_not_load got %b want %b", ctl, C_NORM); end
    tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL lu_stall_cnt2 got %0d want 2", stall_cnt); end
    tick();
  endtask

  task automatic test_mispredict();
    clear_counters();
    set_hazard(5'd5, 1'b1, 5'd0, 1'b0, 5'd5);
    Miss_Prediction = 1'b1;
    #1;
    tests++; if (ctl !== C_MISP) begin fails++; $display("FAIL misp_lu got %b want %b", ctl, C_MISP); end
    tick();
    idle();
    #1;
    tests++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      fails++; $display("FAIL misp_cnt got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    clear_counters();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (ctl !== C_FRZ) begin fails++; $display("FAIL mem_freeze%0d got %b want %b", i, ctl, C_FRZ); end
      tick();
    end
    mem_ack = 1'b1;
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL mem_ack_cycle got %b want %b", ctl, C_NORM); end
    tick();
    idle();
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL mem_after got %b want %b", ctl, C_NORM); end
    tests++; if (stall_cnt !== 4'd3) begin fails++; $display("FAIL mem_stall_cnt got %0d want 3", stall_cnt); end
    mem_req = 1'b1; mem_ack = 1'b1;
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL mem_fast_ack got %b want %b", ctl, C_NORM); end
    tick();
    idle();
    #1;
    tests++; if (ctl !== C_NORM || stall_cnt !== 4'd3) begin
      fails++; $display("FAIL mem_fast_after got ctl=%b stall=%0d want %b/3", ctl, stall_cnt, C_NORM);
    end
  endtask

  task automatic test_timeout();
    clear_counters();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (ctl !== C_FRZ) begin fails++; $display("FAIL to_freeze%0d got %b want %b", i, ctl, C_FRZ); end
      tick();
    end
    #1;
    tests++; if (ctl !== C_NORM || mem_err !== 1'b0) begin
      fails++; $display("FAIL to_release got ctl=%b err=%b want %b/0", ctl, mem_err, C_NORM);
    end
    tick();
    idle();
    #1;
    tests++; if (mem_err !== 1'b1 || ctl !== C_NORM) begin
      fails++; $display("FAIL to_err got err=%b ctl=%b want 1/%b", mem_err, ctl, C_NORM);
    end
    tests++; if (stall_cnt !== 4'd4) begin fails++; $display("FAIL to_stall_cnt got %0d want 4", stall_cnt); end
    repeat (3) tick();
    tests++; if (mem_err !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1", mem_err); end
  endtask

  task automatic test_mispredict_freeze();
    clear_counters();
    mem_req = 1'b1; Miss_Prediction = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (ctl !== C_FRZ) begin fails++; $display("FAIL mf_freeze%0d got %b want %b", i, ctl, C_FRZ); end
      tick();
    end
    mem_ack = 1'b1;
    #1;
    tests++; if (ctl !== C_MISP) begin fails++; $display("FAIL mf_release got %b want %b", ctl, C_MISP); end
    tick();
    idle();
    #1;
    tests++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
      fails++; $display("FAIL mf_cnt got flush=%0d stall=%0d want 1/2", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_saturate();
    clear_counters();
    set_hazard(5'd3, 1'b1, 5'd0, 1'b0, 5'd3);
    repeat (20) tick();
    tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall got %0d want 15", stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL sat_clr got %0d want 0", stall_cnt); end
    tick();
    idle();
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL sat_resume got %0d want 1", stall_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    idle();
    mem_req = 1'b1;
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (ctl !== C_RST || mem_err !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      fails++; $display("FAIL rmw_reset got ctl=%b err=%b stall=%0d flush=%0d want %b/0/0/0",
                        ctl, mem_err, stall_cnt, flush_cnt, C_RST);
    end
    tick();
    rst_n = 1'b1;
    mem_req = 1'b0;
    #1;
    tests++; if (ctl !== C_NORM) begin fails++; $display("FAIL rmw_run got %b want %b", ctl, C_NORM); end
    repeat (6) tick();
    tests++; if (mem_err !== 1'b0 || stall_cnt !== 4'd0) begin
      fails++; $display("FAIL rmw_no_err got err=%b stall=%0d want 0/0", mem_err, stall_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_wait();
    test_timeout();
    test_mispredict_freeze();
    test_saturate();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
